wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single register-file write port and the debug writeback trace among NUM_REQ functional-unit result requesters (ALU, LSU, MUL, DIV).
- Sits between the functional units and the scoreboard's commit logic.
- Grants at most one requester per cycle and registers the winner onto the write port with 1-cycle latency.
- Returns a retire notification so the scoreboard can clear the busy bit for that destination.

Parameters:
- NUM_REQ, 4, number of result requesters; fixed-priority index 0 is highest.
- STARVE_LIMIT, 8, cycles a requester may wait before it is force-granted.
- CNT_W, 4, width of each wait counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester result valid
- req_pc  input  32*NUM_REQ  instruction PC; slice i is bits [32i+31:32i]
- req_wen  input  NUM_REQ  result writes a GPR
- req_wnum  input  5*NUM_REQ  destination register
- req_wdata  input  32*NUM_REQ  result data
- req_ready  output  NUM_REQ  one-hot grant, combinational
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- retire_valid  output  1  an instruction retired this cycle
- retire_id  output  $clog2(NUM_REQ)  index of the retiring requester
- debug_wb_pc  output  32  retiring PC
- debug_wb_rf_wen  output  4  {4{rf_we}}
- debug_wb_rf_wnum  output  5  equals rf_waddr
- debug_wb_rf_wdata  output  32  equals rf_wdata

Behaviour:
- Handshake: a transfer on slot i occurs when req_valid[i] && req_ready[i]. A requester holds valid and payload stable until it is granted. req_ready never asserts for a slot whose valid is low.
- Write port has no backpressure. If any valid is high, exactly one grant is issued that cycle. With no valid request, req_ready = 0.
- Grant order (first rule that applies wins):
  1. Starved requests: any valid slot whose wait counter is >= STARVE_LIMIT; lowest index wins among starved slots.
  2. Base policy (see Optional Feature).
- Wait counters, one per slot:
  - Clear when the slot is granted or not valid.
  - Increment when the slot is valid but not granted.
  - Saturate at 2^CNT_W-1.
- Output register, loaded every cycle:
  - On a transfer: retire_valid=1, retire_id=granted index, debug_wb_pc=pc, rf_waddr=wnum, rf_wdata=wdata, rf_we = wen && (wnum != 0).
  - With no transfer: retire_valid=0, rf_we=0; address, data and PC hold their previous values.
- Latency: grant in cycle N → rf_we/retire_valid visible in cycle N+1 → write lands in the register file at the end of cycle N+1.
- A request with wen=0 (store, branch) still takes a slot and retires with rf_we=0. The scoreboard needs its retire.
- A write to $0 retires with rf_we=0 and debug_wb_rf_wen=0.
- Reset (asynchronous, active-high):
  - rf_we=0, retire_valid=0, retire_id=0, rf_waddr=0, rf_wdata=0, debug_wb_pc=0, debug_wb_rf_wen=0.
  - All wait counters 0; round-robin pointer 0.
  - A reset asserted mid-stream discards the registered result; no retire is emitted for it.
- Two results targeting the same wnum in consecutive cycles: written in grant order. Write-after-write ordering is the scoreboard's responsibility.

Optional Feature:
- Macro: WB_ARB_RR_EN.
- Defined:
  - Base policy is round-robin. Search starts at the pointer, wrapping modulo NUM_REQ.
  - After any grant, pointer = granted index + 1 (wraps NUM_REQ-1 → 0).
  - Starvation override is still present and also updates the pointer.
- Undefined:
  - Base policy is fixed priority, index 0 highest.
  - No pointer register exists.

Decomposition:
- lib/defines.vh gains:
  - WB_REQ_WD (=70: pc 32, wen 1, wnum 5, wdata 32).
  - Field offsets for that bundle.
  - DEBUG_WEN_WD=4.
- One sub-module, wb_pick: combinational find-first-set with rotating base, producing a one-hot grant and its index. It is used twice, once for the starved set and once for the base set.
- Wait counters, the pointer and the output register stay in wb_arbiter.

Test Plan:
- Single request: req_valid=0001, pc=0xBFC00000, wnum=5, wdata=0x1234 → ready=0001 same cycle. Next cycle rf_we=1, waddr=5, wdata=0x1234, debug_wb_rf_wen=4'hF, retire_id=0.
- Simultaneous: valid=1111 held for 4 cycles; each slot drops valid once granted.
  - Fixed priority: grants in order 0,1,2,3.
  - RR: pointer 2 at start → grants 2,3,0,1.
- Starvation (fixed priority): slot 0 stays valid for 20 cycles with a new result each cycle; slot 3 is valid throughout. Slot 3 is granted in the cycle after its counter reaches 8, i.e. within 9 cycles. Its counter then clears to 0.
- $0 and no-write: wnum=0, wen=1 → retire_valid=1, rf_we=0, debug_wb_rf_wen=0. A wen=0 request also retires with rf_we=0.
- Reset: assert rst asynchronously in the cycle after a grant → rf_we and retire_valid drop to 0 immediately; counters and pointer read 0 after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types and constants for the writeback arbiter
//
// Purpose: result-request bundle layout, debug write-enable width and a helper
//          that decides whether a retiring result really writes the register file.
// Ports:   none (package).
// Build option: WB_ARB_RR_EN (consumed by wb_arbiter) selects round-robin base policy.

package wb_arbiter_pkg;

   // Request bundle: {pc[31:0], wen, wnum[4:0], wdata[31:0]}
   localparam int WB_REQ_WD    = 70;
   localparam int WB_PC_LSB    = 38;
   localparam int WB_WEN_BIT   = 37;
   localparam int WB_WNUM_LSB  = 32;
   localparam int WB_WDATA_LSB = 0;
   localparam int DEBUG_WEN_WD = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic        wen;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } wb_req_t;

   // $0 is hardwired to zero, so a write there is suppressed but still retires.
   function automatic logic rf_write_en(input logic wen, input logic [4:0] wnum);
      return wen && (wnum != 5'd0);
   endfunction

endpackage

// File: rtl/wb_pick.sv
// rtl/wb_pick.sv - find-first-set with a rotating base
//
// Purpose: scans req starting at index base, wrapping modulo N, and returns the
//          first set bit as a one-hot grant plus its binary index.
// Ports:   req   [N-1:0]  candidate set
//          base  [IW-1:0] index where the search starts
//          grant [N-1:0]  one-hot winner (zero when req is empty)
//          idx   [IW-1:0] index of the winner (zero when req is empty)
//          any            req has at least one bit set

module wb_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (int'(base) + k) % N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter sharing the register-file write port
//
// Purpose: grants at most one of NUM_REQ functional-unit results per cycle
//          (starved requests first, then the base policy) and registers the
//          winner onto the register-file write port, retire and debug trace.
// Ports:   clk, rst (async, active-high)
//          req_valid/req_pc/req_wen/req_wnum/req_wdata  per-slot result requests
//          req_ready        one-hot combinational grant
//          rf_we/rf_waddr/rf_wdata                      registered write port
//          retire_valid/retire_id                       registered retire notice
//          debug_wb_pc/_rf_wen/_rf_wnum/_rf_wdata       registered trace
// Build option: WB_ARB_RR_EN - round-robin base policy with a rotating pointer;
//          when undefined the base policy is fixed priority (index 0 highest).

module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [32*NUM_REQ-1:0]        req_pc,
   input  logic [NUM_REQ-1:0]           req_wen,
   input  logic [5*NUM_REQ-1:0]         req_wnum,
   input  logic [32*NUM_REQ-1:0]        req_wdata,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         rf_we,
   output logic [4:0]                   rf_waddr,
   output logic [31:0]                  rf_wdata,
   output logic                         retire_valid,
   output logic [$clog2(NUM_REQ)-1:0]   retire_id,
   output logic [31:0]                  debug_wb_pc,
   output logic [DEBUG_WEN_WD-1:0]      debug_wb_rf_wen,
   output logic [4:0]                   debug_wb_rf_wnum,
   output logic [31:0]                  debug_wb_rf_wdata
);

   localparam int IW = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   wb_req_t             req [NUM_REQ];
   logic [NUM_REQ-1:0]  starved;
   logic [NUM_REQ-1:0]  s_grant, b_grant;
   logic [IW-1:0]       s_idx, b_idx, gnt_idx, base;
   logic                s_any, b_any;

   logic [CNT_W-1:0]    cnt_q [NUM_REQ];
   logic [CNT_W-1:0]    cnt_d [NUM_REQ];

   logic                rf_we_q, rf_we_d;
   logic                retire_valid_q, retire_valid_d;
   logic [IW-1:0]       retire_id_q, retire_id_d;
   logic [4:0]          rf_waddr_q, rf_waddr_d;
   logic [31:0]         rf_wdata_q, rf_wdata_d;
   logic [31:0]         pc_q, pc_d;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i].pc    = req_pc[32*i +: 32];
         req[i].wen   = req_wen[i];
         req[i].wnum  = req_wnum[5*i +: 5];
         req[i].wdata = req_wdata[32*i +: 32];
         starved[i]   = req_valid[i] && (cnt_q[i] >= CNT_W'(STARVE_LIMIT));
      end
   end

`ifdef WB_ARB_RR_EN
   logic [IW-1:0] ptr_q, ptr_d;

   assign base = ptr_q;

   // Any grant, starved or not, moves the pointer past the winner.
   always_comb begin
      ptr_d = ptr_q;
      if (|req_valid)
         ptr_d = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`else
   assign base = '0;
`endif

   wb_pick #(.N(NUM_REQ), .IW(IW)) u_pick_starved (
      .req(starved), .base(IW'(0)), .grant(s_grant), .idx(s_idx), .any(s_any)
   );

   wb_pick #(.N(NUM_REQ), .IW(IW)) u_pick_base (
      .req(req_valid), .base(base), .grant(b_grant), .idx(b_idx), .any(b_any)
   );

   // b_any alone decides whether a grant exists; starved is a subset of valid.
   assign req_ready = s_any ? s_grant : b_grant;
   assign gnt_idx   = s_any ? s_idx   : b_idx;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!req_valid[i] || req_ready[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == CNT_MAX)      cnt_d[i] = cnt_q[i];
         else                               cnt_d[i] = cnt_q[i] + 1'b1;
      end
   end

   always_comb begin
      rf_we_d        = 1'b0;
      retire_valid_d = 1'b0;
      retire_id_d    = retire_id_q;
      rf_waddr_d     = rf_waddr_q;
      rf_wdata_d     = rf_wdata_q;
      pc_d           = pc_q;
      if (b_any) begin
         retire_valid_d = 1'b1;
         retire_id_d    = gnt_idx;
         rf_we_d        = rf_write_en(req[gnt_idx].wen, req[gnt_idx].wnum);
         rf_waddr_d     = req[gnt_idx].wnum;
         rf_wdata_d     = req[gnt_idx].wdata;
         pc_d           = req[gnt_idx].pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
         rf_we_q        <= 1'b0;
         retire_valid_q <= 1'b0;
         retire_id_q    <= '0;
         rf_waddr_q     <= '0;
         rf_wdata_q     <= '0;
         pc_q           <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
         rf_we_q        <= rf_we_d;
         retire_valid_q <= retire_valid_d;
         retire_id_q    <= retire_id_d;
         rf_waddr_q     <= rf_waddr_d;
         rf_wdata_q     <= rf_wdata_d;
         pc_q           <= pc_d;
      end
   end

   assign rf_we             = rf_we_q;
   assign rf_waddr          = rf_waddr_q;
   assign rf_wdata          = rf_wdata_q;
   assign retire_valid      = retire_valid_q;
   assign retire_id         = retire_id_q;
   assign debug_wb_pc       = pc_q;
   assign debug_wb_rf_wen   = {DEBUG_WEN_WD{rf_we_q}};
   assign debug_wb_rf_wnum  = rf_waddr_q;
   assign debug_wb_rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
//
// Purpose: drives hand-built request vectors and compares the grant, write port,
//          retire and trace outputs against hand-computed values.
// Ports:   none (top-level bench). Honours WB_ARB_RR_EN for the grant order.

module tb_wb_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [127:0] req_pc;
   logic [3:0]   req_wen;
   logic [19:0]  req_wnum;
   logic [127:0] req_wdata;
   logic [3:0]   req_ready;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;
   logic         retire_valid;
   logic [1:0]   retire_id;
   logic [31:0]  debug_wb_pc;
   logic [3:0]   debug_wb_rf_wen;
   logic [4:0]   debug_wb_rf_wnum;
   logic [31:0]  debug_wb_rf_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.NUM_REQ(4), .STARVE_LIMIT(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_pc(req_pc), .req_wen(req_wen),
      .req_wnum(req_wnum), .req_wdata(req_wdata), .req_ready(req_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retire_valid(retire_valid), .retire_id(retire_id),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   task automatic set_slot(input int i, input logic v, input logic [31:0] pc,
                           input logic wen, input logic [4:0] wnum, input logic [31:0] wdata);
      req_valid[i]          = v;
      req_pc[32*i +: 32]    = pc;
      req_wen[i]            = wen;
      req_wnum[5*i +: 5]    = wnum;
      req_wdata[32*i +: 32] = wdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Keeps slot 0 busy with a fresh result every cycle; returns the cycle
   // offset at which slot 3 (held valid by the caller) is first granted.
   // Leaves time inside that grant cycle. -1 means the budget ran out.
   task automatic wait_slot3(output int cycles);
      cycles = -1;
      for (int c = 0; c < 20 && cycles < 0; c++) begin
         set_slot(0, 1'b1, 32'h3000 + 32'(c), 1'b1, 5'd1, 32'h100 + 32'(c));
         #1;
         if (req_ready[3]) cycles = c;
         else              next_cycle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0; req_pc = '0; req_wen = '0; req_wnum = '0; req_wdata = '0;
      #12;
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
      n_checks++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire_valid: got %b want 0", retire_valid); end
      n_checks++; if (retire_id !== 2'd0) begin n_fail++; $display("FAIL reset_retire_id: got %0d want 0", retire_id); end
      n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
      n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
      n_checks++; if (debug_wb_pc !== 32'd0) begin n_fail++; $display("FAIL reset_debug_pc: got %h want 0", debug_wb_pc); end
      n_checks++; if (debug_wb_rf_wen !== 4'h0) begin n_fail++; $display("FAIL reset_debug_wen: got %h want 0", debug_wb_rf_wen); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_idle: got %b want 0000", req_ready); end
      @(negedge clk);
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_single();
      set_slot(0, 1'b1, 32'hBFC00000, 1'b1, 5'd5, 32'h1234);
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
      next_cycle();
      set_slot(0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_rf_we: got %b want 1", rf_we); end
      n_checks++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
      n_checks++; if (rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL single_wdata: got %h want 1234", rf_wdata); end
      n_checks++; if (debug_wb_rf_wen !== 4'hF) begin n_fail++; $display("FAIL single_debug_wen: got %h want f", debug_wb_rf_wen); end
      n_checks++; if (retire_valid !== 1'b1 || retire_id !== 2'd0) begin n_fail++; $display("FAIL single_retire: got %b/%0d want 1/0", retire_valid, retire_id); end
      n_checks++; if (debug_wb_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL single_debug_pc: got %h want bfc00000", debug_wb_pc); end
      n_checks++; if (debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL single_debug_trace: got %0d/%h want 5/1234", debug_wb_rf_wnum, debug_wb_rf_wdata); end
      #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_idle: got %b want 0000", req_ready); end
      next_cycle();
      n_checks++; if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL single_idle_retire: got %b/%b want 0/0", retire_valid, rf_we); end
      n_checks++; if (rf_waddr !== 5'd5 || debug_wb_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL single_hold: got %0d/%h want 5/bfc00000", rf_waddr, debug_wb_pc); end
   endtask

   task automatic test_simultaneous();
      int order [4];
`ifdef WB_ARB_RR_EN
      order = '{2, 3, 0, 1};
`else
      order = '{0, 1, 2, 3};
`endif
      // A lone grant to slot 1 leaves the round-robin pointer at 2.
      set_slot(1, 1'b1, 32'h1100, 1'b1, 5'd1, 32'h11);
      next_cycle();
      for (int i = 0; i < 4; i++)
         set_slot(i, 1'b1, 32'h1000 + 32'(4*i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (req_ready !== 4'(1 << order[k])) begin n_fail++; $display("FAIL simul_ready_%0d: got %b want %b", k, req_ready, 4'(1 << order[k])); end
         next_cycle();
         n_checks++; if (retire_id !== 2'(order[k]) || rf_wdata !== 32'hA0 + 32'(order[k])) begin n_fail++; $display("FAIL simul_retire_%0d: got %0d/%h want %0d/%h", k, retire_id, rf_wdata, order[k], 32'hA0 + 32'(order[k])); end
         n_checks++; if (rf_waddr !== 5'(10 + order[k])) begin n_fail++; $display("FAIL simul_waddr_%0d: got %0d want %0d", k, rf_waddr, 10 + order[k]); end
         set_slot(order[k], 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      end
      next_cycle();
   endtask

   task automatic test_zero_write();
      set_slot(2, 1'b1, 32'h2000, 1'b1, 5'd0, 32'h55);
      #1;
      n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL zero_ready: got %b want 0100", req_ready); end
      next_cycle();
      set_slot(2, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (retire_valid !== 1'b1 || retire_id !== 2'd2) begin n_fail++; $display("FAIL zero_retire: got %b/%0d want 1/2", retire_valid, retire_id); end
      n_checks++; if (rf_we !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin n_fail++; $display("FAIL zero_rf_we: got %b/%h want 0/0", rf_we, debug_wb_rf_wen); end
      set_slot(1, 1'b1, 32'h2004, 1'b0, 5'd7, 32'h66);
      #1;
      next_cycle();
      set_slot(1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_checks++; if (retire_valid !== 1'b1 || retire_id !== 2'd1) begin n_fail++; $display("FAIL nowrite_retire: got %b/%0d want 1/1", retire_valid, retire_id); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL nowrite_rf_we: got %b want 0", rf_we); end
      n_checks++; if (rf_waddr !== 5'd7 || debug_wb_pc !== 32'h2004) begin n_fail++; $display("FAIL nowrite_trace: got %0d/%h want 7/2004", rf_waddr, debug_wb_pc); end
      next_cycle();
   endtask

   task automatic test_starvation();
      int cyc;
      set_slot(3, 1'b1, 32'h4000, 1'b1, 5'd3, 32'hDEAD);
      wait_slot3(cyc);
      n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL starve_latency: got %0d want 8", cyc); end
      n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL starve_ready: got %b want 1000", req_ready); end
      next_cycle();
      n_checks++; if (retire_id !== 2'd3 || rf_wdata !== 32'hDEAD) begin n_fail++; $display("FAIL starve_retire: got %0d/%h want 3/dead", retire_id, rf_wdata); end
      // A cleared counter means the next request waits the full limit again.
      set_slot(3, 1'b1, 32'h4004, 1'b1, 5'd3, 32'hBEEF);
      wait_slot3(cyc);
      n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL starve_cleared: got %0d want 8", cyc); end
      next_cycle();
      n_checks++; if (retire_id !== 2'd3 || rf_wdata !== 32'hBEEF) begin n_fail++; $display("FAIL starve_retire2: got %0d/%h want 3/beef", retire_id, rf_wdata); end
      req_valid = '0;
      next_cycle();
   endtask

   task automatic test_reset_mid();
      int cyc;
      set_slot(3, 1'b1, 32'h5000, 1'b1, 5'd3, 32'h77);
      for (int c = 0; c < 4; c++) begin
         set_slot(0, 1'b1, 32'h5100 + 32'(c), 1'b1, 5'd9, 32'hAA);
         next_cycle();
      end
      // Slot 0 was granted in the last cycle in either policy.
      n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_we: got %b want 1", rf_we); end
      req_valid = '0;
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (rf_we !== 1'b0 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got %b/%b want 0/0", rf_we, retire_valid); end
      n_checks++; if (rf_waddr !== 5'd0 || debug_wb_pc !== 32'd0) begin n_fail++; $display("FAIL rstmid_regs: got %0d/%h want 0/0", rf_waddr, debug_wb_pc); end
      @(negedge clk);
      rst = 1'b0;
      set_slot(0, 1'b1, 32'h6000, 1'b1, 5'd2, 32'h99);
      set_slot(3, 1'b1, 32'h6004, 1'b1, 5'd3, 32'h88);
      #1;
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant: got %b want 0001", req_ready); end
      next_cycle();
      n_checks++; if (retire_valid !== 1'b1 || retire_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_retire: got %b/%0d want 1/0", retire_valid, retire_id); end
`ifndef WB_ARB_RR_EN
      wait_slot3(cyc);
      n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL rstmid_counter: got %0d want 7", cyc); end
`endif
      req_valid = '0;
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_zero_write();
`ifndef WB_ARB_RR_EN
      test_starvation();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
